// File: rtl/ppm_decoder.sv
// 4-PPM serial frame decoder: hunts for SOF, decodes 2-bit symbols into bytes,
// and reports frame completion or framing/coding errors.
module ppm_decoder #(
  parameter int MAX_BYTES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [7:0] Dout,
  output logic       Dout_valid,
  output logic       frame_done,
  output logic [3:0] frame_len,
  output logic       frame_err
);

  // state | meaning
  // HUNT  | slide a 4-chip window over Din looking for SOF
  // DATA  | chip-aligned symbol decoding, bytes assembled MSB pair first
  // END   | single cycle carrying the frame_done/frame_err pulse
  typedef enum logic [1:0] {HUNT, DATA, END} state_t;

  localparam logic [3:0] SOF   = 4'b1001;
  localparam logic [3:0] EOF   = 4'b0110;
  localparam logic [3:0] MAX_B = 4'(MAX_BYTES);

  state_t     state, state_nxt;
  logic [3:0] win, win_nxt;
  logic [2:0] chips, chips_nxt;
  logic [1:0] chip_cnt, chip_cnt_nxt;
  logic [1:0] sym_cnt, sym_cnt_nxt;
  logic [3:0] byte_cnt, byte_cnt_nxt;
  logic [5:0] byte_sh, byte_sh_nxt;
  logic [7:0] dout_nxt;
  logic       valid_nxt, done_nxt, err_nxt;
  logic [3:0] len_nxt;

  logic [3:0] sym;
  logic       sym_hot;
  logic [1:0] sym_val;

  // Oldest chip sits in bit 3, so a high first chip decodes as value 0.
  assign sym = {chips, Din};

  always_comb begin
    sym_hot = 1'b1;
    sym_val = 2'd0;
    case (sym)
      4'b1000: sym_val = 2'd0;
      4'b0100: sym_val = 2'd1;
      4'b0010: sym_val = 2'd2;
      4'b0001: sym_val = 2'd3;
      default: sym_hot = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    win_nxt      = win;
    chips_nxt    = chips;
    chip_cnt_nxt = chip_cnt;
    sym_cnt_nxt  = sym_cnt;
    byte_cnt_nxt = byte_cnt;
    byte_sh_nxt  = byte_sh;
    dout_nxt     = Dout;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    len_nxt      = 4'd0;

    case (state)
      HUNT: begin
        win_nxt = {win[2:0], Din};
        if ({win[2:0], Din} == SOF) begin
          state_nxt    = DATA;
          win_nxt      = 4'd0;
          chip_cnt_nxt = 2'd0;
        end
      end

      DATA: begin
        chip_cnt_nxt = chip_cnt + 2'd1;
        chips_nxt    = {chips[1:0], Din};
        if (chip_cnt == 2'd3) begin
          if (sym_hot) begin
            sym_cnt_nxt = sym_cnt + 2'd1;
            byte_sh_nxt = {byte_sh[3:0], sym_val};
            if (sym_cnt == 2'd3) begin
              if (byte_cnt == MAX_B) begin
                err_nxt   = 1'b1;
                state_nxt = END;
              end else begin
                dout_nxt     = {byte_sh, sym_val};
                valid_nxt    = 1'b1;
                byte_cnt_nxt = byte_cnt + 4'd1;
              end
            end
          end else if (sym == EOF && sym_cnt == 2'd0 && byte_cnt != 4'd0) begin
            done_nxt  = 1'b1;
            len_nxt   = byte_cnt;
            state_nxt = END;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = END;
          end

          if (state_nxt == END) begin
            win_nxt      = 4'd0;
            chips_nxt    = 3'd0;
            chip_cnt_nxt = 2'd0;
            sym_cnt_nxt  = 2'd0;
            byte_cnt_nxt = 4'd0;
            byte_sh_nxt  = 6'd0;
          end
        end
      end

      END: begin
        // The chip seen during the pulse cycle already counts toward the next SOF.
        win_nxt   = {3'b000, Din};
        state_nxt = HUNT;
      end

      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win        <= 4'd0;
      chips      <= 3'd0;
      chip_cnt   <= 2'd0;
      sym_cnt    <= 2'd0;
      byte_cnt   <= 4'd0;
      byte_sh    <= 6'd0;
      Dout       <= 8'd0;
      Dout_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= 4'd0;
      frame_err  <= 1'b0;
    end else begin
      win        <= win_nxt;
      chips      <= chips_nxt;
      chip_cnt   <= chip_cnt_nxt;
      sym_cnt    <= sym_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      byte_sh    <= byte_sh_nxt;
      Dout       <= dout_nxt;
      Dout_valid <= valid_nxt;
      frame_done <= done_nxt;
      frame_len  <= len_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed bench for ppm_decoder: chips driven one per clock, outputs checked
// with immediate assertions 1 time unit after the sampling edge.
module tb_ppm_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Din = 1'b0;
  logic [7:0] Dout;
  logic       Dout_valid;
  logic       frame_done;
  logic [3:0] frame_len;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  int         n_valid = 0;
  int         n_done  = 0;
  int         n_err   = 0;
  int         n_clash = 0;
  logic [3:0] last_len = 4'd0;
  logic [7:0] got_q[$];

  ppm_decoder #(.MAX_BYTES(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (Din),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Dout_valid) begin
      n_valid++;
      got_q.push_back(Dout);
    end
    if (frame_done) begin
      n_done++;
      last_len = frame_len;
    end
    if (frame_err) n_err++;
    if ((Dout_valid && frame_done) || (frame_done && frame_err)) n_clash++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_chip(input logic b);
    Din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [3:0] s);
    for (int i = 3; i >= 0; i--) send_chip(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [1:0] v;
    for (int i = 3; i >= 0; i--) begin
      v = b[2*i +: 2];
      send_sym(4'b1000 >> v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_chip(1'b0);
  endtask

  int b_valid, b_done, b_err, b_q;

  task automatic mark;
    b_valid = n_valid;
    b_done  = n_done;
    b_err   = n_err;
    b_q     = got_q.size();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",  Dout, 8'h00);
    check("rst_valid", Dout_valid, 0);
    check("rst_done",  frame_done, 0);
    check("rst_len",   frame_len, 0);
    check("rst_err",   frame_err, 0);
    rst = 1'b0;
    idle(3);

    // single byte 0xB4 built from explicit chip groups
    mark();
    send_sym(4'b1001);
    send_sym(4'b0010);
    send_sym(4'b0001);
    send_sym(4'b0100);
    send_sym(4'b1000);
    check("b4_valid", Dout_valid, 1);
    check("b4_dout",  Dout, 8'hB4);
    send_sym(4'b0110);
    check("b4_done",  frame_done, 1);
    check("b4_len",   frame_len, 1);
    check("b4_err",   frame_err, 0);
    check("b4_valid_during_done", Dout_valid, 0);
    idle(1);
    check("b4_pulse_gone", frame_done, 0);
    idle(2);
    check("b4_nvalid", n_valid - b_valid, 1);

    // 15-byte frame
    mark();
    send_sym(4'b1001);
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    send_sym(4'b0110);
    idle(3);
    check("f15_nvalid", n_valid - b_valid, 15);
    for (int i = 0; i < 15; i++) check("f15_byte", got_q[b_q + i], i);
    check("f15_ndone", n_done - b_done, 1);
    check("f15_len",   last_len, 15);
    check("f15_nerr",  n_err - b_err, 0);

    // 16-byte frame overflows
    mark();
    send_sym(4'b1001);
    for (int i = 0; i < 16; i++) send_byte(8'(i + 16));
    check("f16_err",   frame_err, 1);
    check("f16_valid", Dout_valid, 0);
    check("f16_dout_hold", Dout, 8'h1E);
    idle(3);
    check("f16_nvalid", n_valid - b_valid, 15);
    check("f16_ndone",  n_done - b_done, 0);
    check("f16_nerr",   n_err - b_err, 1);

    // EOF at mid-byte position, then a good frame
    mark();
    send_sym(4'b1001);
    send_sym(4'b1000);
    send_sym(4'b0100);
    send_sym(4'b0110);
    check("mid_eof_err",  frame_err, 1);
    check("mid_eof_done", frame_done, 0);
    idle(3);
    check("mid_eof_nvalid", n_valid - b_valid, 0);
    send_sym(4'b1001);
    send_byte(8'h5A);
    check("after_mid_dout", Dout, 8'h5A);
    send_sym(4'b0110);
    check("after_mid_done", frame_done, 1);
    check("after_mid_len",  frame_len, 1);
    idle(3);

    // EOF with zero bytes
    send_sym(4'b1001);
    send_sym(4'b0110);
    check("zero_eof_err",  frame_err, 1);
    check("zero_eof_done", frame_done, 0);
    idle(3);

    // two-high symbol, then the decoder must be hunting again
    mark();
    send_sym(4'b1001);
    send_sym(4'b0011);
    check("bad_sym_err", frame_err, 1);
    idle(3);
    send_sym(4'b1001);
    send_byte(8'h3C);
    check("after_bad_dout", Dout, 8'h3C);
    send_sym(4'b0110);
    check("after_bad_done", frame_done, 1);
    idle(3);
    check("bad_sym_nerr", n_err - b_err, 1);

    // SOF found on the sliding window after unaligned lead-in chips
    send_chip(1'b0);
    send_chip(1'b0);
    send_chip(1'b1);
    send_chip(1'b0);
    send_chip(1'b0);
    send_chip(1'b1);
    send_byte(8'hC3);
    check("slide_valid", Dout_valid, 1);
    check("slide_dout",  Dout, 8'hC3);
    send_sym(4'b0110);
    check("slide_done", frame_done, 1);
    idle(3);

    // reset mid-byte
    mark();
    send_sym(4'b1001);
    send_sym(4'b0001);
    send_sym(4'b0010);
    rst = 1'b1;
    send_chip(1'b1);
    check("mid_rst_dout",  Dout, 8'h00);
    check("mid_rst_valid", Dout_valid, 0);
    check("mid_rst_done",  frame_done, 0);
    check("mid_rst_len",   frame_len, 0);
    check("mid_rst_err",   frame_err, 0);
    rst = 1'b0;
    send_chip(1'b0);
    send_chip(1'b0);
    send_chip(1'b0);
    send_sym(4'b1000);
    idle(3);
    check("mid_rst_nvalid", n_valid - b_valid, 0);
    check("mid_rst_ndone",  n_done - b_done, 0);
    check("mid_rst_nerr",   n_err - b_err, 0);
    send_sym(4'b1001);
    send_byte(8'hE1);
    check("post_rst_dout", Dout, 8'hE1);
    send_sym(4'b0110);
    check("post_rst_done", frame_done, 1);
    check("post_rst_len",  frame_len, 1);
    idle(3);

    check("no_clash", n_clash, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
